// File: rtl/app_pkg.sv
// Shared application state codes and menu indices, used by the sequencer and the display/7-seg output mux.
// Pure definitions: no latency, no flow control.
package app_pkg;

  localparam logic [3:0] ST_LOCKED      = 4'b1111;
  localparam logic [3:0] ST_MENU        = 4'b0000;
  localparam logic [3:0] ST_VOLUME      = 4'b0001;
  localparam logic [3:0] ST_POKEMON     = 4'b0010;
  localparam logic [3:0] ST_POKE_OVER   = 4'b0011;
  localparam logic [3:0] ST_FRUIT       = 4'b0100;
  localparam logic [3:0] ST_POTION      = 4'b0101;
  localparam logic [3:0] ST_LOADING     = 4'b0110;
  localparam logic [3:0] ST_POTION_LOSE = 4'b0111;
  localparam logic [3:0] ST_POTION_WIN  = 4'b1000;
  localparam logic [3:0] ST_FRUIT_OVER  = 4'b1001;

  localparam logic [1:0] SEL_VOLUME  = 2'd0;
  localparam logic [1:0] SEL_POKEMON = 2'd1;
  localparam logic [1:0] SEL_FRUIT   = 2'd2;
  localparam logic [1:0] SEL_POTION  = 2'd3;

  function automatic logic [3:0] game_state(input logic [1:0] sel);
    logic [3:0] st;
    case (sel)
      SEL_VOLUME:  st = ST_VOLUME;
      SEL_POKEMON: st = ST_POKEMON;
      SEL_FRUIT:   st = ST_FRUIT;
      default:     st = ST_POTION;
    endcase
    return st;
  endfunction

  function automatic logic is_result(input logic [3:0] st);
    return (st == ST_POKE_OVER) || (st == ST_POTION_LOSE) ||
           (st == ST_POTION_WIN) || (st == ST_FRUIT_OVER);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter with sync clear/enable; done is combinational on cnt==term while enabled.
// No backpressure; clear has priority over enable.
module dwell_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = enable && (cnt == term);

endmodule

// File: rtl/app_state_ctrl.sv
// Application sequencer: lock/menu/loading/game/result states with registered state, cursor and game_start.
// All outputs change one clock after the causing event pulse; inputs are never stalled.
module app_state_ctrl
  import app_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES   = 200_000_000,
  parameter int unsigned RESULT_CYCLES = 300_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       unlock,
  input  logic       lock_req,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnC,
  input  logic       btnL,
  input  logic       poke_done,
  input  logic       potion_win,
  input  logic       potion_lose,
  input  logic       fruit_done,
  output logic [3:0] state,
  output logic [1:0] menu_sel,
  output logic       game_start
);

  localparam logic [CNT_W-1:0] LOAD_TERM   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESULT_TERM = CNT_W'(RESULT_CYCLES - 1);

  logic [3:0] state_r, state_nxt;
  logic [1:0] sel_r, sel_nxt;
  logic [1:0] target_r, target_nxt;
  logic       gs_r, gs_nxt;
  logic       tmr_en, tmr_clr, tmr_done;
  logic [CNT_W-1:0] tmr_term;

  assign tmr_en   = (state_r == ST_LOADING) || is_result(state_r);
  assign tmr_term = (state_r == ST_LOADING) ? LOAD_TERM : RESULT_TERM;
  // Any state change restarts the dwell count, so the two timed phases can share one counter.
  assign tmr_clr  = (state_nxt != state_r);

  dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .term   (tmr_term),
    .done   (tmr_done)
  );

  always_comb begin
    state_nxt  = state_r;
    sel_nxt    = sel_r;
    target_nxt = target_r;
    gs_nxt     = 1'b0;
    if (lock_req) begin
      state_nxt = ST_LOCKED;
    end else begin
      case (state_r)
        ST_LOCKED: if (unlock) state_nxt = ST_MENU;
        ST_MENU: begin
          if (btnC) begin
            state_nxt  = ST_LOADING;
            target_nxt = sel_r;
          end else if (btnU && !btnD) begin
            sel_nxt = sel_r - 2'd1;
          end else if (btnD && !btnU) begin
            sel_nxt = sel_r + 2'd1;
          end
        end
        ST_LOADING: begin
          if (btnL) begin
            state_nxt = ST_MENU;
          end else if (tmr_done) begin
            state_nxt = game_state(target_r);
            gs_nxt    = 1'b1;
          end
        end
        ST_VOLUME: if (btnL) state_nxt = ST_MENU;
        ST_POKEMON: begin
          if (poke_done)  state_nxt = ST_POKE_OVER;
          else if (btnL)  state_nxt = ST_MENU;
        end
        ST_FRUIT: begin
          if (fruit_done) state_nxt = ST_FRUIT_OVER;
          else if (btnL)  state_nxt = ST_MENU;
        end
        ST_POTION: begin
          if (potion_win)       state_nxt = ST_POTION_WIN;
          else if (potion_lose) state_nxt = ST_POTION_LOSE;
          else if (btnL)        state_nxt = ST_MENU;
        end
        ST_POKE_OVER, ST_POTION_LOSE, ST_POTION_WIN, ST_FRUIT_OVER:
          if (btnC || tmr_done) state_nxt = ST_MENU;
        default: state_nxt = ST_LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_LOCKED;
      sel_r    <= SEL_VOLUME;
      target_r <= SEL_VOLUME;
      gs_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      sel_r    <= sel_nxt;
      target_r <= target_nxt;
      gs_r     <= gs_nxt;
    end
  end

  assign state      = state_r;
  assign menu_sel   = sel_r;
  assign game_start = gs_r;

endmodule

// File: tb/tb_app_state_ctrl.sv
// Directed bench for app_state_ctrl with LOAD_CYCLES=4, RESULT_CYCLES=6.
// Each step pushes its expected {state, menu_sel, game_start} and pops it one edge later.
module tb_app_state_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       unlock = 1'b0, lock_req = 1'b0;
  logic       btnU = 1'b0, btnD = 1'b0, btnC = 1'b0, btnL = 1'b0;
  logic       poke_done = 1'b0, potion_win = 1'b0, potion_lose = 1'b0, fruit_done = 1'b0;
  logic [3:0] state;
  logic [1:0] menu_sel;
  logic       game_start;

  localparam logic [9:0] E_NONE = 10'b0000000000;
  localparam logic [9:0] E_UNL  = 10'b1000000000;
  localparam logic [9:0] E_LOCK = 10'b0100000000;
  localparam logic [9:0] E_U    = 10'b0010000000;
  localparam logic [9:0] E_D    = 10'b0001000000;
  localparam logic [9:0] E_C    = 10'b0000100000;
  localparam logic [9:0] E_L    = 10'b0000010000;
  localparam logic [9:0] E_POKE = 10'b0000001000;
  localparam logic [9:0] E_WIN  = 10'b0000000100;
  localparam logic [9:0] E_LOSE = 10'b0000000010;
  localparam logic [9:0] E_FRT  = 10'b0000000001;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [1:0] sel;
    logic       gs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  app_state_ctrl #(.LOAD_CYCLES(4), .RESULT_CYCLES(6), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .unlock      (unlock),
    .lock_req    (lock_req),
    .btnU        (btnU),
    .btnD        (btnD),
    .btnC        (btnC),
    .btnL        (btnL),
    .poke_done   (poke_done),
    .potion_win  (potion_win),
    .potion_lose (potion_lose),
    .fruit_done  (fruit_done),
    .state       (state),
    .menu_sel    (menu_sel),
    .game_start  (game_start)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [9:0] ev);
    {unlock, lock_req, btnU, btnD, btnC, btnL, poke_done, potion_win, potion_lose, fruit_done} = ev;
  endtask

  task automatic expect_push(input string tag, input logic [3:0] st, input logic [1:0] sel, input logic gs);
    exp_t e;
    e.tag = tag; e.st = st; e.sel = sel; e.gs = gs;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed st=%h sel=%0d gs=%0b required a queued expectation",
             state, menu_sel, game_start);
    end else begin
      e = sb.pop_front();
      assert ({state, menu_sel, game_start} === {e.st, e.sel, e.gs}) else begin
        n_err++;
        $error("FAIL %s: observed st=%h sel=%0d gs=%0b expected st=%h sel=%0d gs=%0b",
               e.tag, state, menu_sel, game_start, e.st, e.sel, e.gs);
      end
    end
  endtask

  // One clock: drive the pulse at negedge, sample #1 after the next posedge.
  task automatic step(input logic [9:0] ev, input string tag,
                      input logic [3:0] st, input logic [1:0] sel, input logic gs);
    @(negedge clk);
    apply(ev);
    expect_push(tag, st, sel, gs);
    @(posedge clk);
    #1;
    apply(E_NONE);
    check_pop();
  endtask

  initial begin
    // reset held for two edges
    apply(E_NONE);
    reset = 1'b1;
    expect_push("reset", 4'hF, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_pop();
    @(negedge clk);
    reset = 1'b0;

    step(E_C,   "locked_ignores_btnC", 4'hF, 2'd0, 1'b0);
    step(E_UNL, "unlock_to_menu",      4'h0, 2'd0, 1'b0);
    step(E_U,   "up_wraps_0_to_3",     4'h0, 2'd3, 1'b0);
    step(E_D,   "down_wraps_3_to_0",   4'h0, 2'd0, 1'b0);
    step(E_D,   "down_to_1",           4'h0, 2'd1, 1'b0);
    step(E_U | E_D, "up_down_together",4'h0, 2'd1, 1'b0);
    step(E_POKE,"stray_done_in_menu",  4'h0, 2'd1, 1'b0);

    // btnC at t: LOADING at t+1, POKEMON with game_start at t+5
    step(E_C, "sel_pokemon_loading", 4'h6, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(E_NONE, "loading_hold", 4'h6, 2'd1, 1'b0);
    step(E_NONE, "enter_pokemon_gs",   4'h2, 2'd1, 1'b1);
    step(E_NONE, "gs_one_cycle",       4'h2, 2'd1, 1'b0);
    step(E_POKE, "poke_over",          4'h3, 2'd1, 1'b0);
    step(E_C,    "dismiss_poke_over",  4'h0, 2'd1, 1'b0);

    step(E_D, "cursor_fruit",  4'h0, 2'd2, 1'b0);
    step(E_D, "cursor_potion", 4'h0, 2'd3, 1'b0);
    step(E_C, "potion_loading", 4'h6, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(E_NONE, "potion_loading_hold", 4'h6, 2'd3, 1'b0);
    step(E_NONE, "enter_potion_gs", 4'h5, 2'd3, 1'b1);
    step(E_WIN | E_LOSE | E_L, "win_beats_lose_and_back", 4'h8, 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) step(E_NONE, "result_hold", 4'h8, 2'd3, 1'b0);
    step(E_NONE, "result_timeout_menu", 4'h0, 2'd3, 1'b0);

    step(E_U, "cursor_to_fruit", 4'h0, 2'd2, 1'b0);
    step(E_C | E_U, "btnC_beats_btnU", 4'h6, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) step(E_NONE, "fruit_loading_hold", 4'h6, 2'd2, 1'b0);
    step(E_NONE, "enter_fruit_gs",  4'h4, 2'd2, 1'b1);
    step(E_WIN,  "stray_win_in_fruit", 4'h4, 2'd2, 1'b0);
    step(E_FRT,  "fruit_over",      4'h9, 2'd2, 1'b0);
    step(E_NONE, "fruit_over_hold", 4'h9, 2'd2, 1'b0);
    step(E_C,    "dismiss_fruit_over", 4'h0, 2'd2, 1'b0);

    step(E_C,    "loading_again",   4'h6, 2'd2, 1'b0);
    step(E_NONE, "loading_again_hold", 4'h6, 2'd2, 1'b0);
    step(E_L,    "loading_abort",   4'h0, 2'd2, 1'b0);
    step(E_NONE, "abort_no_gs",     4'h0, 2'd2, 1'b0);

    // a fresh load after the abort must still take the full dwell
    step(E_U, "cursor_pokemon", 4'h0, 2'd1, 1'b0);
    step(E_C, "reload", 4'h6, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(E_NONE, "reload_hold", 4'h6, 2'd1, 1'b0);
    step(E_NONE, "reenter_pokemon", 4'h2, 2'd1, 1'b1);
    step(E_LOCK, "lock_from_pokemon", 4'hF, 2'd1, 1'b0);
    step(E_L,    "locked_ignores_btnL", 4'hF, 2'd1, 1'b0);

    // illegal code injected through the state register recovers to LOCKED
    @(negedge clk);
    force dut.state_r = 4'b1010;
    #1;
    release dut.state_r;
    expect_push("illegal_injected", 4'hA, 2'd1, 1'b0);
    check_pop();
    step(E_NONE, "illegal_to_locked", 4'hF, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/app_state_ctrl.md
Name: app_state_ctrl

Overview:
- Top-level application sequencer. Produces the 4-bit `state` code consumed by the display/7-seg output mux that selects `oled_data`, `an` and `seg`.
- Handles lock/unlock, the menu cursor, the timed loading screen, game entry/exit and the timed result screens.
- Takes single-cycle event pulses from the debouncers, the unlock logic and the game cores. Drives a one-cycle `game_start` pulse so the game cores can re-initialise.

Parameters:
- LOAD_CYCLES, 200_000_000, clk cycles spent in LOADING before entering the selected game (2 s at 100 MHz).
- RESULT_CYCLES, 300_000_000, clk cycles a result screen (POKE_OVER, POTION_LOSE, POTION_WIN, FRUIT_OVER) is held before auto-return to MENU.
- CNT_W, 32, width of the shared dwell counter; must hold max(LOAD_CYCLES, RESULT_CYCLES).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- unlock  in  1  pulse; password accepted.
- lock_req  in  1  pulse; return to LOCKED from any state.
- btnU  in  1  debounced pulse; cursor up.
- btnD  in  1  debounced pulse; cursor down.
- btnC  in  1  debounced pulse; select / dismiss.
- btnL  in  1  debounced pulse; back to MENU.
- poke_done  in  1  pulse; pokemon game ended.
- potion_win  in  1  pulse; potion game won.
- potion_lose  in  1  pulse; potion game lost.
- fruit_done  in  1  pulse; fruit game ended.
- state  out  4  current state code, registered.
- menu_sel  out  2  menu cursor: 0 volume, 1 pokemon, 2 fruit, 3 potion.
- game_start  out  1  one-cycle pulse on entry to VOLUME, POKEMON, FRUIT or POTION.

Behaviour:
- Shared codes, used unchanged:
  - LOCKED=4'b1111, MENU=0000, VOLUME=0001, POKEMON=0010, POKE_OVER=0011
  - FRUIT=0100, POTION=0101, LOADING=0110, POTION_LOSE=0111, POTION_WIN=1000, FRUIT_OVER=1001
  - Codes 1010–1110 are never produced; if one is reached it becomes LOCKED on the next cycle.
- Reset (sync, cycle after `reset` is sampled high): state=LOCKED, menu_sel=0, target=0, cnt=0, game_start=0.
- Event priority each cycle: reset > lock_req > per-state events. `lock_req` in any state gives LOCKED next cycle and clears cnt; menu_sel is kept.
- LOCKED:
  - `unlock` → MENU.
  - All other inputs ignored.
- MENU:
  - `btnU` alone: menu_sel−1, mod 4 (0 wraps to 3).
  - `btnD` alone: menu_sel+1, mod 4 (3 wraps to 0).
  - `btnU` and `btnD` together: no change.
  - `btnC` → LOADING with target=menu_sel latched and cnt=0. `btnC` takes priority over a simultaneous `btnU`/`btnD`; the cursor does not move.
- LOADING:
  - cnt increments every cycle.
  - When cnt==LOAD_CYCLES−1: go to target's game state (VOLUME/POKEMON/FRUIT/POTION), assert `game_start` for exactly that transition cycle (registered with state), cnt=0.
  - `btnL` → MENU, cnt=0, no `game_start`.
  - Latency from `btnC` to game state = 1 + LOAD_CYCLES cycles.
- VOLUME: `btnL` → MENU.
- POKEMON: `poke_done` → POKE_OVER. `btnL` → MENU.
- FRUIT: `fruit_done` → FRUIT_OVER. `btnL` → MENU.
- POTION:
  - `potion_win` → POTION_WIN; `potion_lose` → POTION_LOSE.
  - Both asserted in the same cycle: POTION_WIN.
  - `btnL` in the same cycle as a done pulse: the done pulse wins.
- Result states:
  - cnt increments; at cnt==RESULT_CYCLES−1, or on `btnC`, → MENU with cnt=0.
  - menu_sel is unchanged so the cursor stays on the last game.
- Done pulses that arrive outside their matching game state are ignored.
- cnt is cleared on every state change and never wraps. The comparison is equality against a CNT_W-bit zero-extended parameter.
- Outputs are registered: `state`, `menu_sel` and `game_start` change only on the clock edge after the causing input.

Decomposition:
- Package `app_pkg`:
  - 4-bit state localparams (codes above), consumed by this block and the output mux.
  - Menu index constants SEL_VOLUME..SEL_POTION.
- Sub-module `dwell_timer` (clear, enable, terminal-count compare, `done` pulse), parameterised by CNT_W. One instance, shared by LOADING and the result states via a mux on the terminal value.

Test Plan (LOAD_CYCLES=4, RESULT_CYCLES=6):
- Assert `reset` 2 cycles → state=1111, menu_sel=0, game_start=0. `btnC` pulse while locked → state stays 1111. `unlock` pulse → state=0000 next cycle.
- In MENU: `btnU` once → menu_sel=3. `btnD` twice → menu_sel=1. `btnU`+`btnD` together → menu_sel stays 1.
- menu_sel=1, `btnC` at cycle t → state=0110 at t+1, state=0010 with game_start=1 at t+5, game_start=0 at t+6.
- In POTION: `potion_win` and `potion_lose` in the same cycle → state=1000. Hold 6 cycles with no input → state=0000, menu_sel=3.
- In FRUIT: `fruit_done` → 1001. `btnC` 2 cycles later → 0000. In LOADING: `btnL` → 0000 with no game_start. `lock_req` in POKEMON → 1111.
- Force a illegal code via `reset` release glitch (backdoor state=4'b1010) → 1111 next cycle.
